// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider.
interface seq_divider_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor, is_signed,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, is_signed,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// 32-bit shift-and-subtract divider, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN to compile in two's-complement support (adds the FIX state).
module seq_divider (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic [31:0] dvd_mag, dvs_mag;
  logic [32:0] shifted, trial;
  logic        trial_ge;

`ifdef SEQ_DIV_SIGNED_EN
  assign op_signed = bus.is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
  assign op_signed        = 1'b0;
`endif

  assign dvd_mag = (op_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
  assign dvs_mag = (op_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;

  // The partial remainder stays below the divisor, so its top bit is always zero here.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[32];

  assign shifted  = {rem_q[31:0], quo_q[31]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign trial_ge = (shifted >= {1'b0, dvs_q});

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dvd_d     = bus.dividend;
          dvs_d     = dvs_mag;
          quo_d     = dvd_mag;
          rem_d     = '0;
          neg_quo_d = op_signed & (bus.dividend[31] ^ bus.divisor[31]);
          neg_rem_d = op_signed & bus.dividend[31];
          dbz_d     = (bus.divisor == 32'd0);
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        rem_d = trial_ge ? trial : shifted;
        quo_d = {quo_q[30:0], trial_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
`ifdef SEQ_DIV_SIGNED_EN
          state_d = StFix;
`else
          state_d = StDone;
`endif
        end
      end
      StFix: begin
        if (neg_quo_q) quo_d = -quo_q;
        if (neg_rem_q) rem_d = {1'b0, -rem_q[31:0]};
        state_d = StDone;
      end
      StDone: begin
        // A zero divisor reports all-ones and hands back the untouched dividend.
        quotient_d  = dbz_q ? 32'hFFFF_FFFF : quo_q;
        remainder_d = dbz_q ? dvd_q : rem_q[31:0];
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
// Build with SEQ_DIV_SIGNED_EN to exercise the signed configuration.
module tb_seq_divider;

`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SignedBuild = 1'b1;
  localparam int Latency     = 34;
`else
  localparam bit SignedBuild = 1'b0;
  localparam int Latency     = 33;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_divider_if bus ();

  seq_divider u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (SignedBuild && s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    int n;
    logic [31:0] eq, er;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (!bus.done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_latency"}, n, Latency);
    ref_div(a, b, s, eq, er);
    check_eq({tag, "_quo"}, bus.quotient, eq);
    check_eq({tag, "_rem"}, bus.remainder, er);
    check_eq({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, b == 32'd0});
    check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] a, b;
    logic s;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_quo", bus.quotient, 32'd0);
    check_eq("rst_rem", bus.remainder, 32'd0);
    check_eq("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d100_7", 32'd100, 32'd7, 1'b0);
    run_div("ffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div("d5_9", 32'd5, 32'd9, 1'b0);
    run_div("d1234_0", 32'd1234, 32'd0, 1'b0);
    run_div("d8_2", 32'd8, 32'd2, 1'b0);
    run_div("m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div("m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 15);
        1:       b = 32'd0;
        2:       b = -($urandom_range(1, 9));
        default: b = $urandom();
      endcase
      s = 1'(($urandom() & 1) == 1);
      run_div($sformatf("rnd%0d", i), a, b, s);
    end

    // A start while busy must be ignored: one done, original result.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    bus.is_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd999;
    bus.divisor  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check_eq("busy_start_dones", dones, 1);
    check_eq("busy_start_quo", bus.quotient, 32'd14);
    check_eq("busy_start_rem", bus.remainder, 32'd2);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_quo", bus.quotient, 32'd0);
    check_eq("abort_rem", bus.remainder, 32'd0);
    check_eq("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    run_div("after_rst", 32'd100, 32'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
